conv_scheduler: RTL

Sequences one shared conv engine across up to MAX_KERNELS filters (output channels) of a layer. Per pass it loads that filter's weights, clears and enables the engine, waits for its done, and captures the ofmap. It then streams the ofmap out through a valid/ready handshake. It sits between the layer controller (start/done) and the conv engine plus downstream ofmap buffer.

---
 rtl/conv_sched_pkg.sv | 24 ++
 rtl/conv_scheduler_if.sv | 23 ++
 rtl/conv_sched_watchdog.sv | 33 +++
 rtl/conv_scheduler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared types and geometry helpers for the conv scheduler.
//   state_t  : scheduler FSM states
//   out_dim  : ofmap dimension from ifmap/kernel/padding/stride geometry
//   idx_w    : index width for an n-entry range (minimum 1 bit)
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    FINISH
  } state_t;

  function automatic int unsigned out_dim(input int unsigned dim, input int unsigned k,
                                          input int unsigned pad, input int unsigned stride);
    return (dim + 2 * pad - k) / stride + 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_scheduler_if.sv
// conv_scheduler_if: ofmap output stream (valid/ready) from the scheduler to
// the downstream ofmap buffer.
//   out_ofmap [OH][OW] x DATA_WIDTH : captured engine result
//   out_ch    CH_W                  : filter index of out_ofmap
//   out_valid                       : out_ofmap/out_ch valid
//   out_ready                       : downstream accepts the beat
// Modports: master (scheduler side), slave (buffer side).
interface conv_scheduler_if #(
  parameter int unsigned OH         = 6,
  parameter int unsigned OW         = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CH_W       = 2
) ();

  logic [OH-1:0][OW-1:0][DATA_WIDTH-1:0] out_ofmap;
  logic [CH_W-1:0]                       out_ch;
  logic                                  out_valid;
  logic                                  out_ready;

  modport master (output out_ofmap, output out_ch, output out_valid, input out_ready);
  modport slave  (input out_ofmap, input out_ch, input out_valid, output out_ready);

endinterface

// File: rtl/conv_sched_watchdog.sv
// conv_sched_watchdog: counts consecutive cycles with run high; the count
// clears whenever run is low, so it restarts on every entry to RUN.
//   clk, reset (async, active-low)
//   run     in  : scheduler is in RUN
//   expired out : run has been high for TIMEOUT_CYCLES cycles (this is the last)
module conv_sched_watchdog
  import conv_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = idx_w(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = run && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/conv_scheduler.sv
// conv_scheduler: runs one shared conv engine over up to MAX_KERNELS filters.
// Each pass: CLEAR (load weights, engine held in reset) -> RUN (engine enabled
// until eng_done) -> DRAIN (ofmap beat offered on the output stream). After the
// last filter, FINISH pulses done.
// Ports:
//   clk, reset (async, active-low)
//   start, num_kernels            : layer request, sampled in IDLE only
//   weight_bank                   : all filter weights
//   busy, done, error             : layer status (error sticky, cleared by start)
//   eng_reset, eng_en, eng_weights: engine control
//   eng_done, eng_ofmap           : engine result
//   ofm (conv_scheduler_if.master): ofmap output stream
// Optional: CONV_SCHED_TIMEOUT_EN adds a RUN watchdog (TIMEOUT_CYCLES) that
// aborts the layer with error=1; without it error stays 0.
module conv_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned MAX_KERNELS    = 4,
  parameter int unsigned IFMAP_HEIGHT   = 6,
  parameter int unsigned IFMAP_WIDTH    = 6,
  parameter int unsigned KERNEL_HEIGHT  = 3,
  parameter int unsigned KERNEL_WIDTH   = 3,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned H_STRIDE       = 1,
  parameter int unsigned V_STRIDE       = 1,
  parameter int unsigned PADDING        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [$clog2(MAX_KERNELS+1)-1:0] num_kernels,
  input  logic signed [MAX_KERNELS-1:0][KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][DATA_WIDTH-1:0] weight_bank,
  output logic busy,
  output logic done,
  output logic error,
  output logic eng_reset,
  output logic eng_en,
  output logic signed [KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][DATA_WIDTH-1:0] eng_weights,
  input  logic eng_done,
  input  logic [out_dim(IFMAP_HEIGHT, KERNEL_HEIGHT, PADDING, V_STRIDE)-1:0]
               [out_dim(IFMAP_WIDTH, KERNEL_WIDTH, PADDING, H_STRIDE)-1:0]
               [DATA_WIDTH-1:0] eng_ofmap,
  conv_scheduler_if.master ofm
);

  localparam int unsigned CH_W = idx_w(MAX_KERNELS);
  localparam int unsigned NK_W = $clog2(MAX_KERNELS + 1);

  state_t          state, state_next;
  logic [CH_W-1:0] k;
  logic [CH_W-1:0] k_last;
  logic [NK_W-1:0] n_eff;
  logic            handshake;
  logic            expired;

  always_comb begin
    n_eff = (num_kernels > NK_W'(MAX_KERNELS)) ? NK_W'(MAX_KERNELS) : num_kernels;
  end

  assign handshake = ofm.out_valid && ofm.out_ready;

`ifdef CONV_SCHED_TIMEOUT_EN
  conv_sched_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .run    (state == RUN),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Engine control is decoded from state: only RUN releases the engine.
  always_comb begin
    state_next = state;
    eng_reset  = 1'b1;
    eng_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (n_eff != '0) ? CLEAR : FINISH;
        end
      end
      CLEAR: begin
        state_next = RUN;
      end
      RUN: begin
        eng_reset = 1'b0;
        eng_en    = 1'b1;
        if (eng_done) begin
          state_next = DRAIN;
        end else if (expired) begin
          state_next = FINISH;
        end
      end
      DRAIN: begin
        if (handshake) begin
          state_next = (k == k_last) ? FINISH : CLEAR;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      k             <= '0;
      k_last        <= '0;
      eng_weights   <= '0;
      ofm.out_ofmap <= '0;
      ofm.out_ch    <= '0;
      ofm.out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            error <= 1'b0;
            k     <= '0;
            if (n_eff != '0) begin
              k_last <= CH_W'(n_eff - NK_W'(1));
            end
          end
        end
        CLEAR: begin
          eng_weights <= weight_bank[k];
        end
        RUN: begin
          if (eng_done) begin
            ofm.out_ofmap <= eng_ofmap;
            ofm.out_ch    <= k;
            ofm.out_valid <= 1'b1;
          end else if (expired) begin
            error <= 1'b1;
          end
        end
        DRAIN: begin
          if (handshake) begin
            ofm.out_valid <= 1'b0;
            if (k != k_last) begin
              k <= k + CH_W'(1);
            end
          end
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
